// File: rtl/clk_ratio_monitor.sv
// Monitors clk2f/clkf (sampled as data on clk8f) for half-period length and
// edge alignment, reporting lock, per-event error strobes and a saturating count.
module clk_ratio_monitor #(
  parameter int unsigned HALF_2F    = 2,
  parameter int unsigned HALF_F     = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk8f,
  input  logic                 reset,
  input  logic                 clk2f_in,
  input  logic                 clkf_in,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned HALF_MAX = (HALF_2F > HALF_F) ? HALF_2F : HALF_F;
  localparam int unsigned LEN_W    = $clog2(HALF_MAX + 3);
  localparam int unsigned GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [LEN_W-1:0]     LEN_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_CHECK   = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // bit 0 = clk2f channel, bit 1 = clkf channel
  logic [1:0]           s_q, s_d, prev_q, prev_d, armed_q, armed_d;
  logic [LEN_W-1:0]     len2_q, len2_d, lenf_q, lenf_d;
  state_e               state_q, state_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic                 locked_q, locked_d, pulse_q, pulse_d;
  logic [2:0]           code_q, code_d;
  logic [ERR_CNT_W-1:0] count_q, count_d;

  logic [1:0] tog;
  logic       chk, per2, perf, phase, err;

  always_comb begin
    s_d      = {clkf_in, clk2f_in};
    prev_d   = s_q;
    tog      = s_q ^ prev_q;
    chk      = (state_q != ST_ACQUIRE);
    // A missed edge flags once at len==HALF; the late edge then flags again.
    per2     = chk && armed_q[0] &&
               (tog[0] ? (len2_q != LEN_W'(HALF_2F)) : (len2_q == LEN_W'(HALF_2F)));
    perf     = chk && armed_q[1] &&
               (tog[1] ? (lenf_q != LEN_W'(HALF_F)) : (lenf_q == LEN_W'(HALF_F)));
    phase    = chk && armed_q[1] && tog[1] && !tog[0];
    err      = per2 || perf || phase;

    len2_d   = tog[0] ? LEN_W'(1) : ((len2_q == LEN_MAX) ? len2_q : len2_q + LEN_W'(1));
    lenf_d   = tog[1] ? LEN_W'(1) : ((lenf_q == LEN_MAX) ? lenf_q : lenf_q + LEN_W'(1));
    armed_d  = armed_q | tog;

    state_d  = state_q;
    good_d   = good_q;
    unique case (state_q)
      ST_ACQUIRE: begin
        if (&armed_q) begin
          state_d = ST_CHECK;
          good_d  = '0;
        end
      end
      ST_CHECK: begin
        if (err) begin
          good_d = '0;
        end else if (tog[1]) begin
          good_d = good_q + GOOD_W'(1);
          if (good_q == GOOD_W'(LOCK_COUNT - 1)) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (err) begin
          state_d = ST_CHECK;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_ACQUIRE;
        good_d  = '0;
      end
    endcase

    pulse_d  = err;
    code_d   = {phase, perf, per2};
    count_d  = (err && (count_q != CNT_MAX)) ? count_q + ERR_CNT_W'(1) : count_q;
    locked_d = (state_d == ST_LOCKED);
  end

  // Input sampling keeps running through reset so release never sees a false edge.
  always_ff @(posedge clk8f) begin
    s_q    <= s_d;
    prev_q <= prev_d;
    if (reset) begin
      armed_q  <= '0;
      len2_q   <= '0;
      lenf_q   <= '0;
      state_q  <= ST_ACQUIRE;
      good_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      code_q   <= '0;
      count_q  <= '0;
    end else begin
      armed_q  <= armed_d;
      len2_q   <= len2_d;
      lenf_q   <= lenf_d;
      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      code_q   <= code_d;
      count_q  <= count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_code  = code_q;
  assign err_count = count_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: generated divided clocks with injected faults,
// compared every cycle against a history-based reference model.
module tb_clk_ratio_monitor;

  localparam int H2   = 2;
  localparam int HF   = 4;
  localparam int LOCK = 4;

  logic       clk8f = 1'b0;
  logic       reset, clk2f_in, clkf_in;
  logic       locked, err_pulse, locked2, err_pulse2;
  logic [2:0] err_code, err_code2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [12:0] obs1;
  logic [6:0]  obs2;

  clk_ratio_monitor u_dut (
    .clk8f(clk8f), .reset(reset), .clk2f_in(clk2f_in), .clkf_in(clkf_in),
    .locked(locked), .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count)
  );

  clk_ratio_monitor #(.ERR_CNT_W(2)) u_dut2 (
    .clk8f(clk8f), .reset(reset), .clk2f_in(clk2f_in), .clkf_in(clkf_in),
    .locked(locked2), .err_pulse(err_pulse2), .err_code(err_code2), .err_count(err_count2)
  );

  assign obs1 = {locked, err_pulse, err_code, err_count};
  assign obs2 = {locked2, err_pulse2, err_code2, err_count2};

  always #5 clk8f = ~clk8f;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ph = 0;
  logic inv2 = 1'b0;
  logic invf = 1'b0;
  int dlyf = 0;

  // Reference model: sampled values, last edge cycle per channel, mode 0/1/2.
  logic [1:0] m_x = '0;
  logic [1:0] m_p = '0;
  logic [1:0] m_arm = '0;
  int m_last [2];
  int m_mode = 0;
  int m_good = 0;
  int e_count = 0;
  logic e_locked = 1'b0;
  logic e_pulse = 1'b0;
  logic [2:0] e_code = '0;

  function automatic logic [12:0] exp1();
    int c;
    c = (e_count > 255) ? 255 : e_count;
    return {e_locked, e_pulse, e_code, 8'(c)};
  endfunction

  function automatic logic [6:0] exp2();
    int c;
    c = (e_count > 3) ? 3 : e_count;
    return {e_locked, e_pulse, e_code, 2'(c)};
  endfunction

  function automatic logic gen2();
    int t;
    t = ph;
    return t[1] ^ inv2;
  endfunction

  function automatic logic genf();
    int t;
    t = ph - dlyf;
    return t[2] ^ invf;
  endfunction

  // Drive one cycle, advance the model, then step to just after the next edge.
  task automatic tick(input logic v2, input logic vf, input logic r);
    logic [1:0] tg, per;
    logic       phe, err;
    int         len;
    clk2f_in = v2;
    clkf_in  = vf;
    reset    = r;
    per = '0;
    for (int i = 0; i < 2; i++) begin
      tg[i] = m_x[i] ^ m_p[i];
      len   = cyc - m_last[i];
      if (m_mode != 0 && m_arm[i])
        per[i] = tg[i] ? (len != ((i == 0) ? H2 : HF)) : (len == ((i == 0) ? H2 : HF));
    end
    phe = (m_mode != 0) && m_arm[1] && tg[1] && !tg[0];
    err = (per != 2'b00) || phe;
    if (r) begin
      m_arm = '0; m_mode = 0; m_good = 0; e_count = 0;
      e_pulse = 1'b0; e_code = '0;
      m_last[0] = cyc + 1; m_last[1] = cyc + 1;
    end else begin
      e_pulse = err;
      e_code  = {phe, per[1], per[0]};
      if (err) e_count++;
      case (m_mode)
        0: if (m_arm == 2'b11) begin m_mode = 1; m_good = 0; end
        1: if (err) m_good = 0;
           else if (tg[1]) begin m_good++; if (m_good == LOCK) m_mode = 2; end
        default: if (err) begin m_mode = 1; m_good = 0; end
      endcase
      for (int i = 0; i < 2; i++) if (tg[i]) begin m_arm[i] = 1'b1; m_last[i] = cyc; end
    end
    e_locked = (m_mode == 2);
    m_p = m_x;
    m_x = {vf, v2};
    @(posedge clk8f);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1'($urandom), 1'($urandom), 1'b1);
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL reset_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
      n_chk++;
      if ({locked, err_pulse, err_count} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_zero cyc=%0d locked=%b pulse=%b count=%0d want 0/0/0",
                 cyc, locked, err_pulse, err_count);
      end
    end
  endtask

  task automatic test_ideal();
    int first_f, lock_at;
    logic vf;
    ph = 0; inv2 = 1'b0; invf = 1'b0; dlyf = 0;
    first_f = -1; lock_at = -1;
    for (int k = 0; k < 202; k++) begin
      vf = genf();
      if (k >= 2 && first_f < 0 && vf != clkf_in) first_f = cyc;
      tick(gen2(), vf, (k < 2) ? 1'b1 : 1'b0);
      ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL ideal_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
      if (lock_at < 0 && locked === 1'b1) lock_at = cyc;
    end
    n_chk++;
    if (lock_at < 0 || first_f < 0 || (lock_at - first_f) > 20) begin
      n_fail++;
      $display("FAIL ideal_lock_time lock_at=%0d first_clkf=%0d want delay<=20", lock_at, first_f);
    end
    n_chk++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL ideal_no_errors count=%0d want 0", err_count);
    end
  endtask

  task automatic test_clk2f_stretch();
    logic seen;
    seen = 1'b0;
    while (ph % 4 != 2) begin
      tick(gen2(), genf(), 1'b0); ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL stretch_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
    end
    // clk2f edge held one cycle late (3), next half-period short (1) to realign
    tick(clk2f_in, genf(), 1'b0); ph++;
    for (int k = 0; k < 60; k++) begin
      tick(gen2(), genf(), 1'b0); ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL stretch_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
      if (!seen && err_pulse === 1'b1) begin
        seen = 1'b1;
        n_chk++;
        if (err_code !== 3'b001 || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL stretch_first_event code=%b locked=%b want 001/0", err_code, locked);
        end
      end
    end
    n_chk++;
    if (!seen || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL stretch_relock seen=%b locked=%b want 1/1", seen, locked);
    end
  endtask

  task automatic test_clkf_stall();
    int base, npulse;
    while (ph % 8 != 0) begin
      tick(gen2(), genf(), 1'b0); ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL stall_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
    end
    // clkf stays high through its falling edge; it falls one half-period late
    invf = ~invf;
    base = e_count;
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      tick(gen2(), genf(), 1'b0); ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL stall_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
      if (err_pulse === 1'b1) begin
        npulse++;
        n_chk++;
        if (err_code !== 3'b010) begin
          n_fail++;
          $display("FAIL stall_code cyc=%0d code=%b want 010", cyc, err_code);
        end
      end
    end
    n_chk++;
    if (npulse != 2 || err_count !== 8'(base + 2) || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_summary pulses=%0d count=%0d locked=%b want 2/%0d/1",
               npulse, err_count, locked, base + 2);
    end
  endtask

  task automatic test_clkf_delay();
    logic seen110, any;
    int prev_p;
    seen110 = 1'b0; any = 1'b0; prev_p = -1;
    dlyf = 1;
    for (int k = 0; k < 60; k++) begin
      tick(gen2(), genf(), 1'b0); ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL delay_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
      if (err_pulse === 1'b1) begin
        any = 1'b1;
        if (seen110) begin
          n_chk++;
          if (err_code !== 3'b100 || (cyc - prev_p) != 4) begin
            n_fail++;
            $display("FAIL delay_phase_pulse cyc=%0d code=%b gap=%0d want 100/4", cyc, err_code, cyc - prev_p);
          end
        end else if (err_code === 3'b110) begin
          seen110 = 1'b1;
        end
        prev_p = cyc;
      end
      if (any) begin
        n_chk++;
        if (locked !== 1'b0) begin
          n_fail++;
          $display("FAIL delay_no_relock cyc=%0d locked=%b want 0", cyc, locked);
        end
      end
    end
    n_chk++;
    if (!seen110) begin
      n_fail++;
      $display("FAIL delay_saw_110 seen=%b want 1", seen110);
    end
  endtask

  task automatic test_err_saturate();
    int npulse;
    dlyf = 0; invf = 1'b0; npulse = 0;
    for (int k = 0; k < 42; k++) begin
      tick(gen2(), genf(), (k < 2) ? 1'b1 : 1'b0); ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL sat_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
    end
    tick(gen2(), genf(), 1'b1); ph++;
    n_chk++;
    if (locked !== 1'b0 || e_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_drop locked=%b want 0", locked);
    end
    for (int k = 0; k < 40; k++) begin
      tick(gen2(), genf(), 1'b0); ph++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL sat_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
    end
    n_chk++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_relock locked=%b want 1", locked);
    end
    dlyf = 1;
    for (int k = 0; k < 30; k++) begin
      tick(gen2(), genf(), 1'b0); ph++;
      if (err_pulse === 1'b1) npulse++;
      n_chk++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        n_fail++;
        $display("FAIL sat_model cyc=%0d dut=%h/%h model=%h/%h", cyc, obs1, obs2, exp1(), exp2());
      end
    end
    n_chk++;
    if (npulse < 5 || err_count2 !== 2'd3 || err_count !== 8'(npulse)) begin
      n_fail++;
      $display("FAIL sat_count pulses=%0d count8=%0d count2=%0d want >=5/%0d/3",
               npulse, err_count, err_count2, npulse);
    end
    tick(gen2(), genf(), 1'b1); ph++;
    n_chk++;
    if (obs1 !== 13'd0 || obs2 !== 7'd0) begin
      n_fail++;
      $display("FAIL sat_reset_clear dut=%h/%h want 0/0", obs1, obs2);
    end
  endtask

  initial begin
    reset = 1'b1; clk2f_in = 1'b0; clkf_in = 1'b0;
    m_last[0] = 0; m_last[1] = 0;
    @(posedge clk8f);
    #1;
    test_reset();
    test_ideal();
    test_clk2f_stretch();
    test_clkf_stall();
    test_clkf_delay();
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
